// File: rtl/raster_pkg.sv
// raster_pkg: shared definitions for the raster timing generator.
//   X_BITS_DEFAULT   - default width of horizontal counter / config fields
//   Y_BITS_DEFAULT   - default width of vertical counter / config fields
//   DIV_BITS_DEFAULT - default width of the pixel-clock divider setting
//   geom_t           - packed geometry record at the default widths:
//                      five horizontal fields, five vertical fields, two polarities
package raster_pkg;

  localparam int unsigned X_BITS_DEFAULT   = 11;
  localparam int unsigned Y_BITS_DEFAULT   = 10;
  localparam int unsigned DIV_BITS_DEFAULT = 2;

  typedef struct packed {
    logic signed [X_BITS_DEFAULT-1:0] x0;
    logic signed [X_BITS_DEFAULT-1:0] x_fp;
    logic signed [X_BITS_DEFAULT-1:0] x_s;
    logic signed [X_BITS_DEFAULT-1:0] x_e;
    logic signed [X_BITS_DEFAULT-1:0] x1;
    logic signed [Y_BITS_DEFAULT-1:0] y0;
    logic signed [Y_BITS_DEFAULT-1:0] y_fp;
    logic signed [Y_BITS_DEFAULT-1:0] y_s;
    logic signed [Y_BITS_DEFAULT-1:0] y_e;
    logic signed [Y_BITS_DEFAULT-1:0] y1;
    logic                             hsync_pol;
    logic                             vsync_pol;
  } geom_t;

endpackage

// File: rtl/raster_axis_counter.sv
// raster_axis_counter: one axis (horizontal or vertical) of the raster.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   step                  - advance the position this clk
//   start_pos             - value loaded when the position wraps
//   fp_pos                - first position past the active region
//   sync_s, sync_e        - sync window [sync_s, sync_e)
//   end_pos               - last position before wrapping
//   pos                   - current position (signed)
//   wrap                  - pos == end_pos
//   in_active             - 0 <= pos < fp_pos
//   in_sync               - sync_s <= pos < sync_e (empty when sync_e <= sync_s)
module raster_axis_counter
  import raster_pkg::*;
#(
  parameter int unsigned BITS = X_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic signed [BITS-1:0] start_pos,
  input  logic signed [BITS-1:0] fp_pos,
  input  logic signed [BITS-1:0] sync_s,
  input  logic signed [BITS-1:0] sync_e,
  input  logic signed [BITS-1:0] end_pos,
  output logic signed [BITS-1:0] pos,
  output logic                   wrap,
  output logic                   in_active,
  output logic                   in_sync
);

  logic signed [BITS-1:0] pos_q, pos_d;

  assign wrap = (pos_q == end_pos);

  // Plain increment wraps modulo 2^BITS, so end_pos < start_pos still terminates.
  always_comb begin
    pos_d = pos_q;
    if (step) begin
      pos_d = wrap ? start_pos : pos_q + BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos       = pos_q;
  assign in_active = !pos_q[BITS-1] && (pos_q < fp_pos);
  assign in_sync   = (pos_q >= sync_s) && (pos_q < sync_e);

endmodule

// File: rtl/raster_timing_gen.sv
// raster_timing_gen: programmable raster (video) timing generator.
// Optional feature macro: RASTER_SHADOW_EN - double-buffers geometry/polarity;
// cfg_load captures into a pending set that is applied at the frame wrap.
// Without it the geometry inputs are used live and cfg_pending is tied to 0.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   x0,x_fp,x_s,x_e,x1            - horizontal start, active end, sync start/end, line end
//   y0,y_fp,y_s,y_e,y1            - vertical equivalents
//   hsync_pol, vsync_pol          - 1 = sync active-high
//   div                           - pixel period minus one, in clk cycles
//   cfg_load                      - capture strobe for geometry and polarity
//   pix_en                        - pixel strobe (dc == div)
//   x, y                          - current column / row
//   active, hsync, vsync          - registered timing, one clk behind x/y
//   line_start, frame_start       - one-clk pulses after the line / frame wrap
//   cfg_pending                   - captured config not yet applied
module raster_timing_gen
  import raster_pkg::*;
#(
  parameter int unsigned X_BITS   = X_BITS_DEFAULT,
  parameter int unsigned Y_BITS   = Y_BITS_DEFAULT,
  parameter int unsigned DIV_BITS = DIV_BITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [X_BITS-1:0] x0,
  input  logic signed [X_BITS-1:0] x_fp,
  input  logic signed [X_BITS-1:0] x_s,
  input  logic signed [X_BITS-1:0] x_e,
  input  logic signed [X_BITS-1:0] x1,
  input  logic signed [Y_BITS-1:0] y0,
  input  logic signed [Y_BITS-1:0] y_fp,
  input  logic signed [Y_BITS-1:0] y_s,
  input  logic signed [Y_BITS-1:0] y_e,
  input  logic signed [Y_BITS-1:0] y1,
  input  logic                     hsync_pol,
  input  logic                     vsync_pol,
  input  logic [DIV_BITS-1:0]      div,
  input  logic                     cfg_load,
  output logic                     pix_en,
  output logic signed [X_BITS-1:0] x,
  output logic signed [Y_BITS-1:0] y,
  output logic                     active,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     line_start,
  output logic                     frame_start,
  output logic                     cfg_pending
);

  typedef struct packed {
    logic signed [X_BITS-1:0] x0;
    logic signed [X_BITS-1:0] x_fp;
    logic signed [X_BITS-1:0] x_s;
    logic signed [X_BITS-1:0] x_e;
    logic signed [X_BITS-1:0] x1;
    logic signed [Y_BITS-1:0] y0;
    logic signed [Y_BITS-1:0] y_fp;
    logic signed [Y_BITS-1:0] y_s;
    logic signed [Y_BITS-1:0] y_e;
    logic signed [Y_BITS-1:0] y1;
    logic                     hsync_pol;
    logic                     vsync_pol;
  } geom_w_t;

  geom_w_t geom_in;  // live inputs
  geom_w_t eff;      // geometry in force this clk
  logic signed [X_BITS-1:0] x_start;
  logic signed [Y_BITS-1:0] y_start;

  assign geom_in = {x0, x_fp, x_s, x_e, x1, y0, y_fp, y_s, y_e, y1, hsync_pol, vsync_pol};

  // Pixel divider
  logic [DIV_BITS-1:0] dc_q, dc_d;
  logic                pix_en_raw;

  assign pix_en_raw = (dc_q == div);
  // A live div below the current count forces an immediate wrap.
  assign dc_d       = (dc_q >= div) ? '0 : dc_q + DIV_BITS'(1);
  assign pix_en     = pix_en_raw & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_q <= '0;
    end else begin
      dc_q <= dc_d;
    end
  end

  // Axis counters
  logic x_wrap, y_wrap, x_act, y_act, x_sync, y_sync;
  logic frame_wrap;

  assign frame_wrap = pix_en_raw & x_wrap & y_wrap;

  raster_axis_counter #(
    .BITS (X_BITS)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .step      (pix_en_raw),
    .start_pos (x_start),
    .fp_pos    (eff.x_fp),
    .sync_s    (eff.x_s),
    .sync_e    (eff.x_e),
    .end_pos   (eff.x1),
    .pos       (x),
    .wrap      (x_wrap),
    .in_active (x_act),
    .in_sync   (x_sync)
  );

  raster_axis_counter #(
    .BITS (Y_BITS)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .step      (pix_en_raw & x_wrap),
    .start_pos (y_start),
    .fp_pos    (eff.y_fp),
    .sync_s    (eff.y_s),
    .sync_e    (eff.y_e),
    .end_pos   (eff.y1),
    .pos       (y),
    .wrap      (y_wrap),
    .in_active (y_act),
    .in_sync   (y_sync)
  );

`ifdef RASTER_SHADOW_EN
  geom_w_t pend_q, work_q;
  logic    pending_q, work_valid_q, apply;

  assign apply = frame_wrap & pending_q;

  // Working set is captured from the inputs on the first clk out of reset; until
  // then the inputs are used directly so the first frame has a defined geometry.
  assign eff = work_valid_q ? work_q : geom_in;

  // The wrap position of the frame that applies new config comes from that config.
  assign x_start = apply ? pend_q.x0 : eff.x0;
  assign y_start = apply ? pend_q.y0 : eff.y0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q       <= '0;
      work_valid_q <= 1'b0;
    end else if (!work_valid_q) begin
      work_q       <= geom_in;
      work_valid_q <= 1'b1;
    end else if (apply) begin
      work_q <= pend_q;
    end
  end

  // A load on the wrap clk wins over the clear, so it lands at the next frame wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else if (cfg_load) begin
      pend_q    <= geom_in;
      pending_q <= 1'b1;
    end else if (apply) begin
      pending_q <= 1'b0;
    end
  end

  assign cfg_pending = pending_q;
`else
  logic unused_cfg_load;

  assign unused_cfg_load = cfg_load;
  assign eff             = geom_in;
  assign x_start         = geom_in.x0;
  assign y_start         = geom_in.y0;
  assign cfg_pending     = 1'b0;
`endif

  // Registered timing outputs
  logic active_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= x_act & y_act;
      hsync_q       <= x_sync ^ ~eff.hsync_pol;
      vsync_q       <= y_sync ^ ~eff.vsync_pol;
      line_start_q  <= pix_en_raw & x_wrap;
      frame_start_q <= frame_wrap;
    end
  end

  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Scoreboard bench for raster_timing_gen: the driver advances an integer reference
// model each clk and queues the expected outputs; a monitor on the falling edge pops
// and compares. Line/frame periods are also checked against fixed constants.
module tb_raster_timing_gen;
  import raster_pkg::*;

  localparam int XB = X_BITS_DEFAULT;
  localparam int YB = Y_BITS_DEFAULT;
  localparam int DB = DIV_BITS_DEFAULT;
  localparam int XH = 1 << (XB - 1);
  localparam int YH = 1 << (YB - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_load = 1'b0;
  logic [DB-1:0] div_v = '0;
  geom_t         g;

  logic                 pix_en, active, hsync, vsync, line_start, frame_start, cfg_pending;
  logic signed [XB-1:0] dut_x;
  logic signed [YB-1:0] dut_y;

  raster_timing_gen dut (
    .clk         (clk),
    .reset       (reset),
    .x0          (g.x0),
    .x_fp        (g.x_fp),
    .x_s         (g.x_s),
    .x_e         (g.x_e),
    .x1          (g.x1),
    .y0          (g.y0),
    .y_fp        (g.y_fp),
    .y_s         (g.y_s),
    .y_e         (g.y_e),
    .y1          (g.y1),
    .hsync_pol   (g.hsync_pol),
    .vsync_pol   (g.vsync_pol),
    .div         (div_v),
    .cfg_load    (cfg_load),
    .pix_en      (pix_en),
    .x           (dut_x),
    .y           (dut_y),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int x;
    int y;
    bit pe;
    bit act;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
    bit cp;
  } exp_t;

  exp_t sb[$];

  // Reference model state (plain integers)
  int    m_dc, m_x, m_y;
  bit    m_act, m_hs, m_vs, m_ls, m_fs, m_pend, m_wvalid;
  geom_t m_w, m_pg;

  // Stimulus staged for the next clk
  geom_t         g_n;
  logic [DB-1:0] div_n;

  // Period checks against constants; 0 disables
  int exp_line_period = 0;
  int exp_frame_period = 0;
  int since_ls = -1;
  int since_fs = -1;

  function automatic int wrap_x(input int v);
    return (v >= XH) ? v - 2 * XH : v;
  endfunction

  function automatic int wrap_y(input int v);
    return (v >= YH) ? v - 2 * YH : v;
  endfunction

  function automatic logic signed [XB-1:0] fx(input int v);
    return XB'(v);
  endfunction

  function automatic logic signed [YB-1:0] fy(input int v);
    return YB'(v);
  endfunction

  function automatic geom_t base_geom();
    geom_t r;
    r.x0 = fx(-2); r.x_fp = fx(4); r.x_s = fx(5); r.x_e = fx(6); r.x1 = fx(7);
    r.y0 = fy(-1); r.y_fp = fy(2); r.y_s = fy(3); r.y_e = fy(4); r.y1 = fy(4);
    r.hsync_pol = 1'b1; r.vsync_pol = 1'b1;
    return r;
  endfunction

  function automatic geom_t rand_geom();
    geom_t r;
    int a0, a1, b0, b1;
    a0 = -int'($urandom_range(3, 0));
    a1 = int'($urandom_range(12, 4));
    b0 = -int'($urandom_range(2, 0));
    b1 = int'($urandom_range(5, 1));
    r.x0 = fx(a0); r.x1 = fx(a1);
    r.x_fp = fx(int'($urandom_range(a1 + 1, 0)));
    r.x_s = fx(a0 - 1 + int'($urandom_range(a1 - a0 + 2, 0)));
    r.x_e = fx(a0 - 1 + int'($urandom_range(a1 - a0 + 2, 0)));
    r.y0 = fy(b0); r.y1 = fy(b1);
    r.y_fp = fy(int'($urandom_range(b1 + 1, 0)));
    r.y_s = fy(b0 - 1 + int'($urandom_range(b1 - b0 + 2, 0)));
    r.y_e = fy(b0 - 1 + int'($urandom_range(b1 - b0 + 2, 0)));
    r.hsync_pol = 1'($urandom_range(1, 0));
    r.vsync_pol = 1'($urandom_range(1, 0));
    return r;
  endfunction

  task automatic model_reset();
    m_dc = 0; m_x = 0; m_y = 0;
    m_act = 0; m_hs = 0; m_vs = 0; m_ls = 0; m_fs = 0;
    m_pend = 0; m_wvalid = 0;
  endtask

  // One clk edge of the reference behaviour, using inputs as seen at the edge.
  task automatic model_step();
    geom_t eff, nxt;
    bit    pe, ls, fs, apply;
    bit    in_hs, in_vs;
    if (reset) begin
      model_reset();
      return;
    end
`ifdef RASTER_SHADOW_EN
    eff = m_wvalid ? m_w : g;
`else
    eff = g;
`endif
    pe    = (m_dc == int'(div_v));
    m_act = (m_x >= 0 && m_x < int'(eff.x_fp)) && (m_y >= 0 && m_y < int'(eff.y_fp));
    in_hs = (m_x >= int'(eff.x_s)) && (m_x < int'(eff.x_e));
    in_vs = (m_y >= int'(eff.y_s)) && (m_y < int'(eff.y_e));
    m_hs  = eff.hsync_pol ? in_hs : !in_hs;
    m_vs  = eff.vsync_pol ? in_vs : !in_vs;
    ls    = pe && (m_x == int'(eff.x1));
    fs    = ls && (m_y == int'(eff.y1));
`ifdef RASTER_SHADOW_EN
    apply = fs && m_pend;
`else
    apply = 1'b0;
`endif
    nxt = apply ? m_pg : eff;
    if (pe) begin
      if (ls) begin
        m_x = int'(nxt.x0);
        m_y = (m_y == int'(eff.y1)) ? int'(nxt.y0) : wrap_y(m_y + 1);
      end else begin
        m_x = wrap_x(m_x + 1);
      end
    end
    m_dc = (m_dc >= int'(div_v)) ? 0 : m_dc + 1;
    m_ls = ls;
    m_fs = fs;
`ifdef RASTER_SHADOW_EN
    m_w = nxt;
    m_wvalid = 1'b1;
    if (cfg_load) begin
      m_pg = g;
      m_pend = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
`endif
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.x = m_x; e.y = m_y;
    e.pe = !reset && (m_dc == int'(div_v));
    e.act = m_act; e.hs = m_hs; e.vs = m_vs; e.ls = m_ls; e.fs = m_fs;
    e.cp = m_pend;
    return e;
  endfunction

  // Advance one clk: model sees the old inputs at the edge, new inputs follow at +1.
  task automatic step(input bit rst_v, input bit load_v);
    @(posedge clk);
    model_step();
    #1;
    g = g_n;
    div_v = div_n;
    reset = rst_v;
    cfg_load = load_v;
    if (rst_v) model_reset();
    sb.push_back(make_exp());
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    exp_line_period = 0;
    exp_frame_period = 0;
    since_ls = -1;
    since_fs = -1;
    repeat (n) step(1'b1, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("x", int'(dut_x), e.x);
        check("y", int'(dut_y), e.y);
        check("pix_en", int'(pix_en), int'(e.pe));
        check("active", int'(active), int'(e.act));
        check("hsync", int'(hsync), int'(e.hs));
        check("vsync", int'(vsync), int'(e.vs));
        check("line_start", int'(line_start), int'(e.ls));
        check("frame_start", int'(frame_start), int'(e.fs));
        check("cfg_pending", int'(cfg_pending), int'(e.cp));
        if (line_start) begin
          if (exp_line_period != 0 && since_ls >= 0)
            check("line_period", since_ls + 1, exp_line_period);
          since_ls = 0;
        end else if (since_ls >= 0) begin
          since_ls++;
        end
        if (frame_start) begin
          if (exp_frame_period != 0 && since_fs >= 0)
            check("frame_period", since_fs + 1, exp_frame_period);
          since_fs = 0;
        end else if (since_fs >= 0) begin
          since_fs++;
        end
      end
    end
  end

  // Driver
  initial begin
    geom_t ng;
    int    n;
    int    r;
    bit    ld;
    g = base_geom();
    g_n = g;
    div_n = '0;
    model_reset();

    // Baseline geometry, div=0
    do_reset(3);
    exp_line_period = 10;
    exp_frame_period = 60;
    run(140);

    // Same geometry, div=2
    do_reset(2);
    div_n = DB'(2);
    exp_line_period = 30;
    exp_frame_period = 180;
    run(400);

    // Inverted sync polarity
    div_n = '0;
    g_n.hsync_pol = 1'b0;
    g_n.vsync_pol = 1'b0;
    do_reset(2);
    exp_line_period = 10;
    exp_frame_period = 60;
    run(140);

    // Mid-frame load of a longer line
    g_n = base_geom();
    do_reset(2);
    run(25);
    g_n.x1 = fx(9);
    step(1'b0, 1'b1);
    run(150);

    // Asynchronous reset at x=3,y=1 with config pending
    g_n = base_geom();
    do_reset(2);
    step(1'b0, 1'b0);
    g_n.x1 = fx(9);
    step(1'b0, 1'b1);
    n = 0;
    while (!(dut_x == fx(3) && dut_y == fy(1)) && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("reach_x3_y1", int'(n < 200), 1);
    #2;
`ifdef RASTER_SHADOW_EN
    check("pending_before_reset", int'(cfg_pending), 1);
`else
    check("pending_before_reset", int'(cfg_pending), 0);
`endif
    reset = 1'b1;
    model_reset();
    sb[sb.size() - 1] = make_exp();
    #1;
    check("async_reset_x", int'(dut_x), 0);
    check("async_reset_pending", int'(cfg_pending), 0);
    check("async_reset_hsync", int'(hsync), 0);
    do_reset(3);
    run(80);

    // Line end below line start: counter runs through the modulo wrap
    g_n = base_geom();
    g_n.x0 = fx(3);
    g_n.x1 = fx(1);
    g_n.y0 = fy(0);
    g_n.y1 = fy(1);
    do_reset(2);
    run(2200);

    // Randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      g_n = rand_geom();
      div_n = DB'($urandom_range(3, 0));
      do_reset(2);
      for (int i = 0; i < 300; i++) begin
        r = int'($urandom_range(99, 0));
        ld = 1'b0;
        if (r < 3) begin
          ng = rand_geom();
          if (int'(ng.x1) > m_x && int'(ng.y1) > m_y) begin
            g_n = ng;
            ld = 1'b1;
          end
        end else if (r == 50) begin
          div_n = DB'($urandom_range(3, 0));
        end
        if (r == 77) begin
          step(1'b1, 1'b0);
          step(1'b1, 1'b0);
        end else begin
          step(1'b0, ld);
        end
      end
    end

    run(3);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_timing_gen.md
RASTER_TIMING_GEN -- requirements
Module: raster_timing_gen

Interface
REQ-001 SHALL have parameter X_BITS, default 11, meaning width of the signed horizontal counter and horizontal config fields.
REQ-002 SHALL have parameter Y_BITS, default 10, meaning width of the signed vertical counter and vertical config fields.
REQ-003 SHALL have parameter DIV_BITS, default 2, meaning width of the pixel-clock divider setting.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-005 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- x0, x_fp, x_s, x_e, x1  in  X_BITS signed each  horizontal: line start, active end, sync start, sync end, line end
- y0, y_fp, y_s, y_e, y1  in  Y_BITS signed each  vertical equivalents
- hsync_pol, vsync_pol  in  1 each  1 = sync active-high
- div  in  DIV_BITS  pixel period minus one, in clk cycles
- cfg_load  in  1  one-cycle strobe that captures all geometry and polarity inputs
- pix_en  out  1  pixel strobe
- x  out  X_BITS  current column
- y  out  Y_BITS  current row
- active, hsync, vsync  out  1 each  registered video timing
- line_start, frame_start  out  1 each  one-clk event pulses
- cfg_pending  out  1  captured config not yet applied

Function
REQ-006 SHALL run the divider counter dc from 0 to div and then wrap to 0; pix_en SHALL be high exactly when dc==div, giving one pulse every div+1 clks.
REQ-007 SHALL change x and y only on pix_en cycles; x becomes x0 when x==x1, else x+1 modulo 2^X_BITS.
REQ-008 SHALL change y only on a pix_en cycle where x==x1; y becomes y0 when y==y1, else y+1 modulo 2^Y_BITS.
REQ-009 SHALL register active, hsync and vsync one clk after the counter state they describe, updating them every clk.
REQ-010 SHALL compute active = (0<=x<x_fp) AND (0<=y<y_fp), using signed compares.
REQ-011 SHALL compute hsync = (x_s<=x<x_e) XOR !hsync_pol, and vsync in the same way with the y fields and vsync_pol; when x_e<=x_s the sync window is empty and the output sits at its inactive level.
REQ-012 SHALL pulse line_start high for one clk on the cycle after a pix_en at which x==x1.
REQ-013 SHALL pulse frame_start high for one clk on the cycle after a pix_en at which x==x1 and y==y1; frame_start implies line_start.
REQ-014 SHALL treat div as always live; a change to div takes effect at the next dc wrap, and dc>div SHALL wrap to 0 on the next clk.
REQ-015 SHALL be safe for configurations where x1<x0: the counter runs modulo 2^X_BITS until it reaches x1, with no lock-up. The same applies to y.

Reset
REQ-016 SHALL, while reset is asserted, set x=0, y=0, dc=0, cfg_pending=0 and drive every registered output (active, hsync, vsync, line_start, frame_start) to 0.
REQ-017 SHALL, when reset is asserted mid-frame or mid-divide, discard all in-progress state including pending config; counting restarts from x=0,y=0 with dc=0 on the first clk after release.

Configuration
REQ-018 SHALL, when RASTER_SHADOW_EN is defined, double-buffer the geometry and polarity inputs:
- cfg_load copies them into a pending register and sets cfg_pending.
- At the pix_en where x==x1 and y==y1, pending is copied to the working set and cfg_pending clears.
- The wrap values x0/y0 come from the newly applied set.
- A cfg_load on the wrap cycle itself is captured and applied at the following frame wrap.
- A second cfg_load before the wrap overwrites pending.
REQ-019 SHALL, when RASTER_SHADOW_EN is undefined, use the geometry inputs live, ignore cfg_load and tie cfg_pending to 0.

Structure
REQ-020 SHALL place the default widths (X_BITS, Y_BITS, DIV_BITS) and a packed geometry struct (five horizontal plus five vertical fields and two polarities) in the shared package raster_pkg.
REQ-021 SHALL implement each axis in one sub-module, raster_axis_counter, instantiated twice: inputs are step enable and start/fp/s/e/end fields; outputs are position, wrap flag, in-active and in-sync.

Verification
REQ-022 SHALL cover these directed scenarios:
- div=0, x0=-2,x_fp=4,x_s=5,x_e=6,x1=7, y0=-1,y_fp=2,y_s=3,y_e=4,y1=4, pols=1 -> x sequence 0..7,-2,-1,0; line_start every 10 clks; frame_start every 60 clks; hsync high exactly 1 pixel per line.
- Same geometry, div=2 -> pix_en every 3rd clk; line period 30 clks; x holds for 3 clks.
- hsync_pol=0, vsync_pol=0 -> hsync/vsync are the bitwise inverse of the pol=1 run, cycle-aligned.
- RASTER_SHADOW_EN, cfg_load with x1=9 mid-frame -> cfg_pending=1 and line length stays 10 until frame_start, then 12; cfg_pending clears on that frame_start.
- Without RASTER_SHADOW_EN, same stimulus -> line length becomes 12 from the next line wrap; cfg_pending stays 0.
- Reset asserted at x=3,y=1 with cfg_pending=1 -> all outputs 0 immediately (asynchronous); after release x counts from 0 and cfg_pending=0.
